// File: rtl/zint_mc.sv
// Multi-channel Z80 IM2 interrupt controller: prioritised pending flags, vector
// latch on acknowledge, and a qualified-step pulse counter that auto-drops channels.
module zint_mc #(
    parameter int unsigned     NCH       = 4,
    parameter int unsigned     PULSE_LEN = 32,
    parameter logic [7:0]      VBASE     = 8'hFF,
    parameter logic [NCH-1:0]  AUTODROP  = NCH'(1)
) (
    input  logic           clk,
    input  logic           res_n,
    input  logic           zpos,
    input  logic           wait_n,
    input  logic           vdos,
    input  logic           intack,
    input  logic [NCH-1:0] int_start,
    input  logic [NCH-1:0] intmask,
    input  logic [NCH-1:0] pend_clr,
    output logic [NCH-1:0] pending,
    output logic [7:0]     im2vect,
    output logic           int_n,
    output logic           boost_start
);

    localparam int unsigned SELW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CW   = $clog2(PULSE_LEN) + 1;
    localparam logic [CW-1:0] PLEN = CW'(PULSE_LEN);

    logic [NCH-1:0]  pending_q, pending_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [CW-1:0]   count_q, count_d;
    logic            fin_q, fin_d;
    logic            intack_q, intack_d;
    logic            wait_q, wait_d;

    logic            intack_s, tmo_s, fin, any_pend, found, load;
    logic [SELW-1:0] low_idx;
    logic [NCH-1:0]  low_hot;
    logic [7:0]      sel_x2;

    always_comb begin
        intack_s = intack & ~intack_q;
        fin      = (count_q == PLEN);
        tmo_s    = fin & ~fin_q;
        any_pend = |pending_q;

        low_idx = '0;
        low_hot = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (pending_q[i] && !found) begin
                found      = 1'b1;
                low_idx    = SELW'(i);
                low_hot[i] = 1'b1;
            end
        end

        // Start wins over any clear source in the same clock; mask beats both.
        pending_d = pending_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!intmask[i])
                pending_d[i] = 1'b0;
            else if (int_start[i])
                pending_d[i] = 1'b1;
            else if (pend_clr[i] || (intack_s && low_hot[i]) || (AUTODROP[i] && tmo_s))
                pending_d[i] = 1'b0;
        end

        sel_d = (intack_s && any_pend) ? low_idx : sel_q;

        load    = |(int_start & intmask & AUTODROP);
        count_d = count_q;
        if (load)
            count_d = '0;
        else if (zpos && !fin && !wait_q && !vdos)
            count_d = count_q + CW'(1);

        intack_d = intack;
        wait_d   = ~wait_n;
        fin_d    = fin;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            pending_q <= '0;
            sel_q     <= '0;
            count_q   <= PLEN;
            fin_q     <= 1'b1;
            intack_q  <= 1'b0;
            wait_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            sel_q     <= sel_d;
            count_q   <= count_d;
            fin_q     <= fin_d;
            intack_q  <= intack_d;
            wait_q    <= wait_d;
        end
    end

    assign sel_x2      = 8'({sel_q, 1'b0});
    assign pending     = pending_q;
    assign im2vect     = VBASE - sel_x2;
    assign int_n       = ~(any_pend & ~vdos);
    // Held acknowledge during reset must not leak out as a boost pulse.
    assign boost_start = res_n & (intack_s | tmo_s);

endmodule

// File: tb/tb_zint_mc.sv
// Randomised + directed bench for zint_mc with a queue-based scoreboard
// fed by a behavioural reference model.
module tb_zint_mc;

    localparam int unsigned NCH  = 4;
    localparam int          PLEN = 32;
    localparam logic [7:0]  VB   = 8'hFF;
    localparam logic [3:0]  AD   = 4'b0001;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       zpos = 1'b0, wait_n = 1'b1, vdos = 1'b0, intack = 1'b0;
    logic [3:0] int_start = '0, intmask = '1, pend_clr = '0;
    logic [3:0] pending;
    logic [7:0] im2vect;
    logic       int_n, boost_start;

    zint_mc #(.NCH(NCH), .PULSE_LEN(PLEN), .VBASE(VB), .AUTODROP(AD)) dut (
        .clk(clk), .res_n(res_n), .zpos(zpos), .wait_n(wait_n), .vdos(vdos),
        .intack(intack), .int_start(int_start), .intmask(intmask), .pend_clr(pend_clr),
        .pending(pending), .im2vect(im2vect), .int_n(int_n), .boost_start(boost_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pend;
        logic [7:0] vec;
        logic       intn;
        logic       boost;
        int         n;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   ncyc  = 0;

    // reference model state
    logic [3:0] m_pend = '0;
    int         m_sel = 0, m_cnt = PLEN;
    logic       m_pack = 1'b0, m_pfin = 1'b1, m_wr = 1'b0;

    // per-cycle stimulus globals
    logic       g_rn = 1'b0, g_wn = 1'b1, g_vd = 1'b0;
    logic [3:0] g_mask = 4'hF;

    task automatic drive(input logic [3:0] st, input logic [3:0] pc, input logic ack, input logic zp);
        exp_t       e;
        int         lo;
        logic       ack_s, fin, tmo;
        logic [3:0] np;
        @(posedge clk);
        #1;
        res_n = g_rn; wait_n = g_wn; vdos = g_vd; intmask = g_mask;
        int_start = st; pend_clr = pc; intack = ack; zpos = zp;
        ncyc++;
        e.n = ncyc;
        if (!g_rn) begin
            m_pend = '0; m_sel = 0; m_cnt = PLEN; m_pack = 1'b0; m_pfin = 1'b1; m_wr = 1'b0;
            e.pend = '0; e.vec = VB; e.intn = 1'b1; e.boost = 1'b0;
            q.push_back(e);
            return;
        end
        ack_s = ack && !m_pack;
        fin   = (m_cnt == PLEN);
        tmo   = fin && !m_pfin;
        lo = -1;
        for (int i = 0; i < 4; i++) if (m_pend[i] && lo < 0) lo = i;
        e.pend  = m_pend;
        e.vec   = 8'((int'(VB) + 256 - 2 * m_sel) % 256);
        e.intn  = !(m_pend != 4'b0 && !g_vd);
        e.boost = ack_s || tmo;
        q.push_back(e);
        np = m_pend;
        for (int i = 0; i < 4; i++) begin
            if (!g_mask[i]) np[i] = 1'b0;
            else if (st[i]) np[i] = 1'b1;
            else if (pc[i] || (ack_s && i == lo) || (AD[i] && tmo)) np[i] = 1'b0;
        end
        if (ack_s && lo >= 0) m_sel = lo;
        if ((st & g_mask & AD) != 4'b0) m_cnt = 0;
        else if (zp && !fin && !m_wr && !g_vd) m_cnt = m_cnt + 1;
        m_pack = ack; m_pfin = fin; m_wr = !g_wn; m_pend = np;
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            total++;
            if (pending !== mon_e.pend) begin
                bad++; $display("FAIL pending cyc=%0d got=%b exp=%b", mon_e.n, pending, mon_e.pend);
            end
            total++;
            if (im2vect !== mon_e.vec) begin
                bad++; $display("FAIL im2vect cyc=%0d got=%h exp=%h", mon_e.n, im2vect, mon_e.vec);
            end
            total++;
            if (int_n !== mon_e.intn) begin
                bad++; $display("FAIL int_n cyc=%0d got=%b exp=%b", mon_e.n, int_n, mon_e.intn);
            end
            total++;
            if (boost_start !== mon_e.boost) begin
                bad++; $display("FAIL boost_start cyc=%0d got=%b exp=%b", mon_e.n, boost_start, mon_e.boost);
            end
        end
    end

    initial begin
        logic       ack_l;
        logic [3:0] st, pc;
        // reset
        g_rn = 1'b0;
        repeat (3) drive('0, '0, 1'b0, 1'b0);
        g_rn = 1'b1;

        // single channel, full pulse, auto-drop
        drive(4'b0001, '0, 1'b0, 1'b1);
        repeat (40) drive('0, '0, 1'b0, 1'b1);

        // two starts, two acknowledges
        drive(4'b0110, '0, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        repeat (2) drive('0, '0, 1'b1, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        repeat (2) drive('0, '0, 1'b1, 1'b0);
        drive('0, '0, 1'b0, 1'b0);

        // masking
        g_mask = 4'b0111;
        drive(4'b1000, '0, 1'b0, 1'b0);
        drive(4'b0010, '0, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        g_mask = 4'b1101;
        repeat (2) drive('0, '0, 1'b0, 1'b0);
        g_mask = 4'hF;

        // vdos freeze
        drive(4'b0001, '0, 1'b0, 1'b1);
        repeat (3) drive('0, '0, 1'b0, 1'b1);
        g_vd = 1'b1;
        repeat (10) drive('0, '0, 1'b0, 1'b1);
        g_vd = 1'b0;
        repeat (35) drive('0, '0, 1'b0, 1'b1);

        // start/clear collision, wait freeze
        drive(4'b0100, 4'b0100, 1'b0, 1'b0);
        drive('0, 4'b0100, 1'b0, 1'b0);
        drive(4'b0001, '0, 1'b0, 1'b1);
        repeat (3) drive('0, '0, 1'b0, 1'b1);
        g_wn = 1'b0;
        repeat (5) drive('0, '0, 1'b0, 1'b1);
        g_wn = 1'b1;
        repeat (40) drive('0, '0, 1'b0, 1'b1);

        // reset mid-pulse at count 10
        drive(4'b0001, '0, 1'b0, 1'b1);
        repeat (10) drive('0, '0, 1'b0, 1'b1);
        g_rn = 1'b0;
        repeat (2) drive('0, '0, 1'b0, 1'b1);
        g_rn = 1'b1;
        repeat (40) drive('0, '0, 1'b0, 1'b1);

        // random traffic
        ack_l = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            g_mask = ($urandom % 8 == 0) ? 4'($urandom) : 4'hF;
            g_wn   = ($urandom % 8 != 0);
            g_vd   = ($urandom % 10 == 0);
            g_rn   = ($urandom % 300 != 0);
            st     = ($urandom % 6 == 0) ? 4'($urandom) : 4'b0;
            pc     = ($urandom % 10 == 0) ? 4'($urandom) : 4'b0;
            if ($urandom % 4 == 0) ack_l = ~ack_l;
            drive(st, pc, ack_l, 1'($urandom));
        end
        g_rn = 1'b1;

        for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zint_mc.md
ZINT_MC -- requirements
Module: zint_mc

Interface
REQ-001 SHALL provide parameter NCH, default 4, number of interrupt channels (1..8); channel 0 has highest priority.
REQ-002 SHALL provide parameter PULSE_LEN, default 32, number of qualified counter steps before auto-drop.
REQ-003 SHALL provide parameter VBASE, default 8'hFF, IM2 vector of channel 0.
REQ-004 SHALL provide parameter AUTODROP, default NCH'b1, per-channel enable for timeout drop.
REQ-005 clk  in  1  single system clock; all state changes on its rising edge.
REQ-006 res_n  in  1  reset, asynchronous, active-low.
REQ-007 zpos  in  1  CPU clock-enable strobe; advances pulse counter.
REQ-008 wait_n  in  1  CPU wait, active-low; freezes pulse counter.
REQ-009 vdos  in  1  VDOS active; blocks int_n and counter.
REQ-010 intack  in  1  CPU interrupt acknowledge level.
REQ-011 int_start  in  NCH  per-channel one-clock start strobes.
REQ-012 intmask  in  NCH  per-channel enable, 1 = enabled.
REQ-013 pend_clr  in  NCH  per-channel software clear strobes.
REQ-014 pending  out  NCH  per-channel pending flags.
REQ-015 im2vect  out  8  IM2 vector of latched channel.
REQ-016 int_n  out  1  CPU INT, active-low.
REQ-017 boost_start  out  1  one-clock pulse on acknowledge edge or pulse timeout edge.

Function
REQ-018 intack_s SHALL be intack high while intack registered one clock earlier is low.
REQ-019 wait_r SHALL be !wait_n registered one clock; counter gating uses wait_r.
REQ-020 pending[i] update priority per clock: intmask[i]=0 -> 0; else int_start[i] -> 1; else clear-condition -> 0; else hold.
REQ-021 clear-condition[i] = pend_clr[i], or (intack_s and i is lowest-index pending channel), or (AUTODROP[i] and tmo_s).
REQ-022 Start and clear in same clock SHALL leave pending[i]=1.
REQ-023 On intack_s with any pending, sel SHALL latch lowest-index pending channel; with none pending sel holds.
REQ-024 im2vect SHALL equal (VBASE - 2*sel) modulo 256, combinational from sel.
REQ-025 int_n SHALL be 0 iff any pending bit is 1 and vdos is 0; pending state is retained during vdos.
REQ-026 Pulse counter width clog2(PULSE_LEN)+1; fin = (count == PULSE_LEN).
REQ-027 Any int_start[i] with AUTODROP[i]=1 and intmask[i]=1 SHALL load count to 0 (synchronous, overrides increment).
REQ-028 Counter increments when zpos & !fin & !wait_r & !vdos; saturates at PULSE_LEN.
REQ-029 tmo_s SHALL be one-clock pulse on fin rising (fin registered).
REQ-030 boost_start SHALL equal intack_s | tmo_s.
REQ-031 Acknowledging an auto-drop channel SHALL NOT stop the counter; a later tmo_s clears only channels still pending.

Reset
REQ-032 While res_n=0: pending=0, sel=0, count=PULSE_LEN (fin=1), fin register=1, intack register=0, wait_r=0.
REQ-033 Reset outputs: pending=0, im2vect=VBASE, int_n=1, boost_start=0.
REQ-034 Reset assertion mid-pulse or mid-acknowledge SHALL abort immediately; no tmo_s after release until a new start.

Verification
REQ-035 Reset, start[0], 32 zpos clocks, no ack -> int_n low 32 qualified steps, tmo_s pulse, pending[0]=0, boost_start one clock.
REQ-036 start[1] and start[2] same clock, intack rise -> im2vect=8'hFD, pending=4'b0100, int_n stays 0; second intack -> 8'hFB, int_n=1.
REQ-037 start[3] with intmask[3]=0 -> pending[3] stays 0, int_n=1; mask drop while pending[1]=1 -> pending[1]=0 next clock.
REQ-038 pending[0]=1, vdos=1 for 10 zpos clocks -> int_n=1, count unchanged; vdos=0 -> int_n=0, count resumes.
REQ-039 pend_clr[2] and start[2] same clock -> pending[2]=1; wait_n=0 -> counter frozen two clocks after wait_n falls.
REQ-040 res_n low during active pulse at count=10 -> pending=0, int_n=1 asynchronously, no tmo_s after release.
